// File: rtl/wishbone_arbiter_pkg.sv
// Shared types for the wishbone arbiter: FSM state encoding and a counter-width helper.
// ST_ERR exists only when WB_ARBITER_TIMEOUT_EN is defined.
package wishbone_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1
`ifdef WB_ARBITER_TIMEOUT_EN
    , ST_ERR = 2'd2
`endif
  } arb_state_t;

  // Width for a counter that counts 0..limit-1.
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/wishbone_arbiter_rr_pick.sv
// Round-robin picker: one-hot pick of the first requester after the one-hot last owner,
// wrapping modulo NM; all-zero when nobody requests.
module wishbone_rr_pick #(
  parameter int NM = 3
) (
  input  logic [NM-1:0] req,
  input  logic [NM-1:0] last,
  output logic [NM-1:0] pick
);

  always_comb begin
    int  li;
    int  idx;
    logic found;
    li    = 0;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NM; i++) begin
      if (last[i]) li = i;
    end
    for (int k = 1; k <= NM; k++) begin
      idx = (li + k) % NM;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share one slave, grant held until owner drops cyc.
// Optional stall watchdog enabled by WB_ARBITER_TIMEOUT_EN.
module wishbone_arbiter
  import wishbone_arbiter_pkg::*;
#(
  parameter int NM      = 3,
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TW      = 3,
  parameter int SW      = DW / 8,
  parameter int TIMEOUT = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [NM-1:0]    masters_cyc,
  input  logic [NM-1:0]    masters_stb,
  input  logic [NM-1:0]    masters_we,
  input  logic [NM*TW-1:0] masters_tag,
  input  logic [NM*SW-1:0] masters_sel,
  input  logic [NM*AW-1:0] masters_adr,
  input  logic [NM*DW-1:0] masters_mosi,
  output logic [NM*DW-1:0] masters_miso,
  output logic [NM-1:0]    masters_ack,
  output logic [NM-1:0]    masters_err,
  output logic             slave_cyc,
  output logic             slave_stb,
  output logic             slave_we,
  output logic [TW-1:0]    slave_tag,
  output logic [SW-1:0]    slave_sel,
  output logic [AW-1:0]    slave_adr,
  output logic [DW-1:0]    slave_mosi,
  input  logic [DW-1:0]    slave_miso,
  input  logic             slave_ack,
  input  logic             slave_err,
  output logic [NM-1:0]    grant
);

  arb_state_t    r_state, w_state_nxt;
  logic [NM-1:0] r_grant, w_grant_nxt;
  logic [NM-1:0] r_last, w_last_nxt;
  logic [NM-1:0] w_pick;
  logic          w_owner_cyc;
  logic          w_in_err;

  wishbone_rr_pick #(.NM(NM)) u_rr_pick (
    .req  (masters_cyc),
    .last (r_last),
    .pick (w_pick)
  );

  assign w_owner_cyc = |(masters_cyc & r_grant);
  assign grant       = r_grant;

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam int WDW = cnt_width(TIMEOUT);
  logic [WDW-1:0] r_wdog, w_wdog_nxt;
  logic           w_stall;
  assign w_stall  = slave_stb & ~slave_ack & ~slave_err;
  assign w_in_err = (r_state == ST_ERR);
`else
  assign w_in_err = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state        <= ST_IDLE;
      r_grant        <= '0;
      r_last         <= '0;
      r_last[NM-1]   <= 1'b1;
`ifdef WB_ARBITER_TIMEOUT_EN
      r_wdog         <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
`ifdef WB_ARBITER_TIMEOUT_EN
      r_wdog  <= w_wdog_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
`ifdef WB_ARBITER_TIMEOUT_EN
    w_wdog_nxt  = r_wdog;
`endif
    case (r_state)
      ST_IDLE: begin
        if (|masters_cyc) begin
          w_grant_nxt = w_pick;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!w_owner_cyc) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_grant;
          w_grant_nxt = '0;
`ifdef WB_ARBITER_TIMEOUT_EN
          w_wdog_nxt  = '0;
        end else if (w_stall) begin
          if (r_wdog == WDW'(TIMEOUT - 1)) begin
            w_state_nxt = ST_ERR;
            w_wdog_nxt  = '0;
          end else begin
            w_wdog_nxt  = r_wdog + 1'b1;
          end
        end else begin
          w_wdog_nxt = '0;
`endif
        end
      end
`ifdef WB_ARBITER_TIMEOUT_EN
      ST_ERR: begin
        w_state_nxt = ST_BUSY;
        w_wdog_nxt  = '0;
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // Request path: AND-OR mux keyed on the registered grant, so idle forwards zeros.
  always_comb begin
    slave_cyc  = 1'b0;
    slave_stb  = 1'b0;
    slave_we   = 1'b0;
    slave_tag  = '0;
    slave_sel  = '0;
    slave_adr  = '0;
    slave_mosi = '0;
    for (int i = 0; i < NM; i++) begin
      slave_cyc  = slave_cyc | (r_grant[i] & masters_cyc[i]);
      slave_stb  = slave_stb | (r_grant[i] & masters_stb[i]);
      slave_we   = slave_we  | (r_grant[i] & masters_we[i]);
      slave_tag  = slave_tag  | ({TW{r_grant[i]}} & masters_tag[i*TW +: TW]);
      slave_sel  = slave_sel  | ({SW{r_grant[i]}} & masters_sel[i*SW +: SW]);
      slave_adr  = slave_adr  | ({AW{r_grant[i]}} & masters_adr[i*AW +: AW]);
      slave_mosi = slave_mosi | ({DW{r_grant[i]}} & masters_mosi[i*DW +: DW]);
    end
    if (w_in_err) slave_stb = 1'b0;
  end

  // Response path; reset suppresses strobes in the same cycle so an aborted transfer never completes.
  always_comb begin
    masters_miso = '0;
    masters_ack  = '0;
    masters_err  = '0;
    for (int i = 0; i < NM; i++) begin
      masters_miso[i*DW +: DW] = r_grant[i] ? slave_miso : '0;
      masters_ack[i] = r_grant[i] & slave_ack & ~sys_rst & ~w_in_err;
      masters_err[i] = r_grant[i] & ~sys_rst & (slave_err | w_in_err);
    end
  end

endmodule
